// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl
// Sequential signed multiply/divide unit for the execute stage.
// A start pulse loads a 2*WIDTH working register. The unit then runs WIDTH
// single-bit iterations: radix-2 Booth for multiply, restoring division for
// divide. One sign-fix/exception cycle follows, then a one-cycle done pulse.
//
// Ports:
//   clk            rising-edge clock
//   clr            synchronous active-high reset
//   ctrl_MULT      one-cycle start pulse, multiply (wins over ctrl_DIV)
//   ctrl_DIV       one-cycle start pulse, divide
//   data_operandA  multiplicand / dividend (signed), sampled on start
//   data_operandB  multiplier / divisor (signed), sampled on start
//   data_result    product low word or quotient (registered)
//   data_exception overflow or divide-by-zero flag (registered)
//   data_resultRDY one-cycle pulse when result/exception are valid
//   busy           high while an operation is in flight
module multdiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [5:0]       LAST    = 6'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] w_q, w_d;
    logic               booth_q, booth_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;

    logic               start;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     ext_upper, addend, sum;
    logic [2*WIDTH-1:0] mult_next;
    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quot;

    // Datapath for one Booth step and one restoring-division step.
    // The Booth add is one bit wider than the upper half so that the
    // arithmetic shift right never loses the true sign of the partial sum.
    always_comb begin
        start     = ctrl_MULT | ctrl_DIV;
        abs_a     = data_operandA[WIDTH-1] ? (~data_operandA + ONE) : data_operandA;
        abs_b     = data_operandB[WIDTH-1] ? (~data_operandB + ONE) : data_operandB;

        ext_upper = {w_q[2*WIDTH-1], w_q[2*WIDTH-1:WIDTH]};
        addend    = {a_q[WIDTH-1], a_q};
        case ({w_q[0], booth_q})
            2'b01:   sum = ext_upper + addend;
            2'b10:   sum = ext_upper - addend;
            default: sum = ext_upper;
        endcase
        mult_next = {sum, w_q[WIDTH-1:1]};

        shifted   = {w_q[2*WIDTH-2:0], 1'b0};
        trial     = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, mag_q};
        div_next  = trial[WIDTH] ? shifted
                                 : {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};

        quot      = neg_q ? (~w_q[WIDTH-1:0] + ONE) : w_q[WIDTH-1:0];
    end

    // Next-state logic. A start pulse in any state restarts the unit with
    // fresh operands, which is how both abort and back-to-back issue work;
    // the DONE pulse itself comes from the state register, so it still
    // appears in a cycle that also carries a new start.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        booth_d  = booth_q;
        a_d      = a_q;
        mag_d    = mag_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;

        if (start) begin
            state_d  = ctrl_MULT ? S_MULT : S_DIV;
            cnt_d    = '0;
            booth_d  = 1'b0;
            a_d      = data_operandA;
            mag_d    = abs_b;
            is_div_d = ~ctrl_MULT;
            neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d     = (data_operandB == '0);
            ovf_d    = (data_operandA == MIN_NEG) && (data_operandB == '1);
            w_d      = ctrl_MULT ? {{WIDTH{1'b0}}, data_operandB}
                                 : {{WIDTH{1'b0}}, abs_a};
        end else begin
            case (state_q)
                S_MULT: begin
                    w_d     = mult_next;
                    booth_d = w_q[0];
                    cnt_d   = cnt_q + 6'd1;
                    if (cnt_q == LAST) state_d = S_FIX;
                end
                S_DIV: begin
                    w_d   = div_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST) state_d = S_FIX;
                end
                S_FIX: begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        result_d = w_q[WIDTH-1:0];
                        exc_d    = (w_q[2*WIDTH-1:WIDTH] != {WIDTH{w_q[WIDTH-1]}});
                    end else if (dz_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else if (ovf_q) begin
                        result_d = MIN_NEG;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = quot;
                        exc_d    = 1'b0;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers; reset dominates any start pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            w_q      <= '0;
            booth_q  <= 1'b0;
            a_q      <= '0;
            mag_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            booth_q  <= booth_d;
            a_q      <= a_d;
            mag_q    <= mag_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);
    assign busy           = (state_q != S_IDLE);

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequential signed multiply/divide unit for the processor's execute stage. A small FSM and a 6-bit iteration counter drive a 64-bit working register, which holds product or remainder:quotient, through 32 single-bit iterations. Operation is radix-2 Booth for multiply and restoring division for divide, followed by one sign-fix/exception cycle. The pipeline stalls on `busy` and captures the result on the `data_resultRDY` pulse.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width. The working register is 2×WIDTH wide. Only 32 is verified.

Ports:
- `clk`  in  1  rising-edge clock
- `clr`  in  1  synchronous, active-high reset
- `ctrl_MULT`  in  1  one-cycle start pulse for multiply
- `ctrl_DIV`  in  1  one-cycle start pulse for divide
- `data_operandA`  in  32  multiplicand / dividend, signed two's complement, sampled only on a start cycle
- `data_operandB`  in  32  multiplier / divisor, signed, sampled only on a start cycle
- `data_result`  out  32  product low word, or quotient
- `data_exception`  out  1  overflow or divide-by-zero flag for the current result
- `data_resultRDY`  out  1  one-cycle pulse: result and exception are valid
- `busy`  out  1  high while an operation is in flight

## Operation
States:
- IDLE → MULT or DIV on a start pulse.
- MULT/DIV → FIX after 32 iterations.
- FIX → DONE → IDLE.

Start:
- A start cycle is any cycle with `ctrl_MULT | ctrl_DIV` high in any state.
- On a start cycle, latch both operands, clear the counter and load the working register:
  - multiply: {32'b0, B}, Booth bit 0
  - divide: {32'b0, |A|}, magnitude register = |B|
- Record the op type and result sign (A[31]^B[31] for divide).

MULT step (one per cycle, 32 total):
- Examine {W[0], booth}:
  - 01: add A to the upper half
  - 10: subtract A from the upper half
- Then arithmetic-shift {upper, W, booth} right by 1.
- The upper-half add is 33 bits wide to avoid loss.

DIV step (one per cycle, 32 total):
- Shift W left by 1.
- Compute trial = W[63:32] − |B| (33-bit).
- If trial is non-negative, W[63:32] ← trial and W[0] ← 1.

FIX:
- Multiply: result ← W[31:0]; exception ← 1 iff W[63:32] is not all copies of W[31].
- Divide: quotient ← W[31:0], negated if the sign flag is set.
- Divide by B = 0: result 0, exception 1.
- Divide 0x80000000 / −1: result 0x80000000, exception 1.
- Other divides: exception 0. Quotient truncates toward zero; remainder is discarded.

DONE:
- Assert `data_resultRDY` for one cycle, then go to IDLE.

Outputs and boundary conditions:
- `data_result` and `data_exception` are registered. They update only on the FIX→DONE edge and hold until the next DONE.
- `ctrl_MULT` and `ctrl_DIV` high together: multiply wins, divide ignored.
- Start pulse while busy: abort the current operation and restart with the new operands. No `data_resultRDY` is produced for the aborted op.
- Start pulse in the DONE cycle: `data_resultRDY` still pulses that cycle, and the new op starts.
- Reset takes priority over a start pulse in the same cycle.
- `clr` mid-operation: return to IDLE and drop the op silently.
- Operands that change after the start cycle have no effect.

## Timing
- Reset values: `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `busy` = 0, state IDLE, counter 0.
- Fixed latency for every op, including divide-by-zero: start in cycle 0 → `data_resultRDY` high in cycle 34.
  - Cycles 1–32: iterations.
  - Cycle 33: FIX.
  - Cycle 34: DONE.
- `busy` is high in cycles 1–34 and low again in cycle 35. `busy` is low in the start cycle itself.
- Throughput: back-to-back ops are possible by pulsing start in the DONE cycle, giving one result every 34 cycles.
- No combinational path from any input to any output.

## Test plan
- Multiply 7 × −3: pulse `ctrl_MULT` in cycle 0 → `data_resultRDY` only in cycle 34, `data_result` = 0xFFFFFFEB (−21), `data_exception` = 0, `busy` high in cycles 1–34.
- Multiply overflow 0x40000000 × 4: → `data_result` = 0x00000000, `data_exception` = 1. Also 0x7FFFFFFF × 1 → 0x7FFFFFFF, exception 0.
- Divide −7 / 2 → quotient 0xFFFFFFFD (−3), exception 0. Then 100 / 0 → result 0, exception 1, `data_resultRDY` still in cycle 34. Then 0x80000000 / −1 → 0x80000000, exception 1.
- Abort: pulse `ctrl_DIV` (50/5) in cycle 0, then `ctrl_MULT` (6×6) in cycle 10 → exactly one `data_resultRDY` pulse, in cycle 44, with result 36. Simultaneous `ctrl_MULT` and `ctrl_DIV` (A=6, B=3) → result 18.
- Reset: assert `clr` in cycle 15 of a multiply → next cycle all outputs are 0 and `busy` = 0, and no `data_resultRDY` pulse appears within the following 40 cycles.
- Random signed operand sweep (≥1000 ops of each type) against a reference model, including 0, ±1, 0x7FFFFFFF and 0x80000000 operands. Every result, exception and latency must match.
